// File: rtl/sram_arbiter_if.sv
// Requester-side handshake and memory-side bus of the two-port SRAM arbiter.
// The slave modport is the arbiter's view; master is the requester/SRAM view.
interface sram_arbiter_if #(
   parameter int ADDR_WIDTH = 20,
   parameter int DATA_WIDTH = 8
);
   logic                  i_a_req;
   logic                  i_a_write;
   logic [ADDR_WIDTH-1:0] i_a_addr;
   logic [DATA_WIDTH-1:0] i_a_wdata;
   logic                  o_a_ack;
   logic                  o_a_rvalid;
   logic [DATA_WIDTH-1:0] o_a_rdata;

   logic                  i_b_req;
   logic                  i_b_write;
   logic [ADDR_WIDTH-1:0] i_b_addr;
   logic [DATA_WIDTH-1:0] i_b_wdata;
   logic                  o_b_ack;
   logic                  o_b_rvalid;
   logic [DATA_WIDTH-1:0] o_b_rdata;

   logic                  o_m_write;
   logic [ADDR_WIDTH-1:0] o_m_addr;
   logic [DATA_WIDTH-1:0] o_m_data;
   logic [DATA_WIDTH-1:0] i_m_data;
   logic                  o_busy;

   modport slave (
      input  i_a_req, i_a_write, i_a_addr, i_a_wdata,
      input  i_b_req, i_b_write, i_b_addr, i_b_wdata,
      input  i_m_data,
      output o_a_ack, o_a_rvalid, o_a_rdata,
      output o_b_ack, o_b_rvalid, o_b_rdata,
      output o_m_write, o_m_addr, o_m_data, o_busy
   );

   modport master (
      output i_a_req, i_a_write, i_a_addr, i_a_wdata,
      output i_b_req, i_b_write, i_b_addr, i_b_wdata,
      output i_m_data,
      input  o_a_ack, o_a_rvalid, o_a_rdata,
      input  o_b_ack, o_b_rvalid, o_b_rdata,
      input  o_m_write, o_m_addr, o_m_data, o_busy
   );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port async SRAM; each access
// holds address/data/write for ACCESS_CYCLES cycles, then one RECOVER cycle.
module sram_arbiter #(
   parameter int ADDR_WIDTH    = 20,
   parameter int DATA_WIDTH    = 8,
   parameter int ACCESS_CYCLES = 3
) (
   input  logic            i_clk,
   input  logic            i_n_reset,
   sram_arbiter_if.slave   bus
);
   localparam int            CW       = $clog2(ACCESS_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ACCESS  = 2'd1;
   localparam logic [1:0] ST_RECOVER = 2'd2;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  last_grant_q, last_grant_d;
   logic                  sel_q, sel_d;
   logic                  m_write_q, m_write_d;
   logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic                  a_ack_q, a_ack_d, b_ack_q, b_ack_d;
   logic                  a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
   logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
   logic                  busy_q, busy_d;
   logic                  grant_b;

   // On a tie, B wins only if A was granted last.
   assign grant_b = bus.i_b_req && (!bus.i_a_req || (last_grant_q == PORT_A));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      sel_d        = sel_q;
      m_write_d    = m_write_q;
      m_addr_d     = m_addr_q;
      m_data_d     = m_data_q;
      a_ack_d      = 1'b0;
      b_ack_d      = 1'b0;
      a_rvalid_d   = 1'b0;
      b_rvalid_d   = 1'b0;
      a_rdata_d    = a_rdata_q;
      b_rdata_d    = b_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.i_a_req || bus.i_b_req) begin
               state_d      = ST_ACCESS;
               cnt_d        = CNT_LOAD;
               sel_d        = grant_b;
               last_grant_d = grant_b;
               m_write_d    = grant_b ? bus.i_b_write : bus.i_a_write;
               m_addr_d     = grant_b ? bus.i_b_addr  : bus.i_a_addr;
               m_data_d     = grant_b ? bus.i_b_wdata : bus.i_a_wdata;
               a_ack_d      = !grant_b;
               b_ack_d      = grant_b;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == CNT_ONE) begin
               state_d   = ST_RECOVER;
               cnt_d     = '0;
               m_write_d = 1'b0;
               // m_write_q still carries the latched direction on this last cycle.
               if (!m_write_q) begin
                  if (sel_q == PORT_B) begin
                     b_rdata_d  = bus.i_m_data;
                     b_rvalid_d = 1'b1;
                  end else begin
                     a_rdata_d  = bus.i_m_data;
                     a_rvalid_d = 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_RECOVER: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            m_write_d = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_n_reset) begin
      if (!i_n_reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         last_grant_q <= PORT_B;
         sel_q        <= PORT_A;
         m_write_q    <= 1'b0;
         m_addr_q     <= '0;
         m_data_q     <= '0;
         a_ack_q      <= 1'b0;
         b_ack_q      <= 1'b0;
         a_rvalid_q   <= 1'b0;
         b_rvalid_q   <= 1'b0;
         a_rdata_q    <= '0;
         b_rdata_q    <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         sel_q        <= sel_d;
         m_write_q    <= m_write_d;
         m_addr_q     <= m_addr_d;
         m_data_q     <= m_data_d;
         a_ack_q      <= a_ack_d;
         b_ack_q      <= b_ack_d;
         a_rvalid_q   <= a_rvalid_d;
         b_rvalid_q   <= b_rvalid_d;
         a_rdata_q    <= a_rdata_d;
         b_rdata_q    <= b_rdata_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.o_a_ack    = a_ack_q;
   assign bus.o_a_rvalid = a_rvalid_q;
   assign bus.o_a_rdata  = a_rdata_q;
   assign bus.o_b_ack    = b_ack_q;
   assign bus.o_b_rvalid = b_rvalid_q;
   assign bus.o_b_rdata  = b_rdata_q;
   assign bus.o_m_write  = m_write_q;
   assign bus.o_m_addr   = m_addr_q;
   assign bus.o_m_data   = m_data_q;
   assign bus.o_busy     = busy_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic against a
// transaction-phase reference model; a second instance covers ACCESS_CYCLES=2.
module tb_sram_arbiter;
   localparam int AC = 3;

   logic        i_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_req = 1'b0, a_write = 1'b0, b_req = 1'b0, b_write = 1'b0;
   logic [19:0] a_addr = '0, b_addr = '0;
   logic [7:0]  a_wdata = '0, b_wdata = '0, mdata = '0;
   logic        keep_a = 1'b0, keep_b = 1'b0;

   logic        a2_req = 1'b0, a2_write = 1'b0;
   logic [19:0] a2_addr = '0;
   logic [7:0]  a2_wdata = '0, mdata2 = '0;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int order[$];
   int ack_cyc[$];

   // Reference model: phase 0 = idle, 1..AC = access cycles, AC+1 = recover.
   int          m_ph;
   bit          m_port, m_last, m_wr;
   logic [19:0] m_addr;
   logic [7:0]  m_data, m_rd_a, m_rd_b;

   always #5 i_clk = ~i_clk;

   sram_arbiter_if #(.ADDR_WIDTH(20), .DATA_WIDTH(8)) bus ();
   sram_arbiter_if #(.ADDR_WIDTH(20), .DATA_WIDTH(8)) bus2 ();

   assign bus.i_a_req   = a_req;
   assign bus.i_a_write = a_write;
   assign bus.i_a_addr  = a_addr;
   assign bus.i_a_wdata = a_wdata;
   assign bus.i_b_req   = b_req;
   assign bus.i_b_write = b_write;
   assign bus.i_b_addr  = b_addr;
   assign bus.i_b_wdata = b_wdata;
   assign bus.i_m_data  = mdata;

   assign bus2.i_a_req   = a2_req;
   assign bus2.i_a_write = a2_write;
   assign bus2.i_a_addr  = a2_addr;
   assign bus2.i_a_wdata = a2_wdata;
   assign bus2.i_b_req   = 1'b0;
   assign bus2.i_b_write = 1'b0;
   assign bus2.i_b_addr  = '0;
   assign bus2.i_b_wdata = '0;
   assign bus2.i_m_data  = mdata2;

   sram_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(8), .ACCESS_CYCLES(AC)) dut (
      .i_clk     (i_clk),
      .i_n_reset (rst_n),
      .bus       (bus)
   );

   sram_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(8), .ACCESS_CYCLES(2)) dut2 (
      .i_clk     (i_clk),
      .i_n_reset (rst_n),
      .bus       (bus2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ph = 0; m_port = 1'b0; m_last = 1'b1; m_wr = 1'b0;
      m_addr = '0; m_data = '0; m_rd_a = '0; m_rd_b = '0;
   endtask

   task automatic model_edge();
      if (m_ph == 0) begin
         if (a_req || b_req) begin
            m_port = (a_req && b_req) ? !m_last : b_req;
            m_last = m_port;
            m_wr   = m_port ? b_write : a_write;
            m_addr = m_port ? b_addr  : a_addr;
            m_data = m_port ? b_wdata : a_wdata;
            m_ph   = 1;
         end
      end else if (m_ph <= AC) begin
         m_ph++;
         if (m_ph == AC + 1 && !m_wr) begin
            if (m_port) m_rd_b = mdata; else m_rd_a = mdata;
         end
      end else begin
         m_ph = 0;
      end
   endtask

   task automatic check_all();
      bit acc, rec;
      acc = (m_ph >= 1) && (m_ph <= AC);
      rec = (m_ph == AC + 1);
      check("busy",     32'(bus.o_busy),     32'(m_ph != 0));
      check("a_ack",    32'(bus.o_a_ack),    32'(m_ph == 1 && !m_port));
      check("b_ack",    32'(bus.o_b_ack),    32'(m_ph == 1 && m_port));
      check("a_rvalid", 32'(bus.o_a_rvalid), 32'(rec && !m_wr && !m_port));
      check("b_rvalid", 32'(bus.o_b_rvalid), 32'(rec && !m_wr && m_port));
      check("m_write",  32'(bus.o_m_write),  32'(acc && m_wr));
      check("m_addr",   32'(bus.o_m_addr),   32'(m_addr));
      check("m_data",   32'(bus.o_m_data),   32'(m_data));
      check("a_rdata",  32'(bus.o_a_rdata),  32'(m_rd_a));
      check("b_rdata",  32'(bus.o_b_rdata),  32'(m_rd_b));
   endtask

   task automatic tick();
      @(posedge i_clk);
      if (!rst_n) model_reset(); else model_edge();
      cyc++;
      #1;
      check_all();
      if (bus.o_a_ack) begin order.push_back(0); ack_cyc.push_back(cyc); end
      if (bus.o_b_ack) begin order.push_back(1); ack_cyc.push_back(cyc); end
      if (rst_n && m_ph == 1) begin
         if (!m_port && !keep_a) a_req = 1'b0;
         if (m_port && !keep_b)  b_req = 1'b0;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] saved;
      int wr_cnt, rv_cyc, k0, a2n;
      int ack2[$];
      logic [7:0] rv_dat;

      // Reset asserted: everything zero before any edge; then idle for 10 cycles.
      model_reset();
      #2;
      check_all();
      #10 rst_n = 1'b1;
      ticks(10);

      // A write 0x12345 / 0xA5.
      a_write = 1'b1; a_addr = 20'h12345; a_wdata = 8'hA5; a_req = 1'b1;
      ticks(6);
      check("a_write_done_idle", 32'(bus.o_busy), 32'd0);

      // B read 0xFFFFF returning 0x3C; A's rdata must not move.
      saved = bus.o_a_rdata;
      mdata = 8'h3C; b_write = 1'b0; b_addr = 20'hFFFFF; b_req = 1'b1;
      ticks(4);
      check("b_rvalid_cycle4", 32'(bus.o_b_rvalid), 32'd1);
      check("b_rdata_3c",      32'(bus.o_b_rdata),  32'h3C);
      check("a_rdata_kept",    32'(bus.o_a_rdata),  32'(saved));
      ticks(3);

      // Both reading with requests held: A,B,A,B with acks 5 cycles apart.
      order.delete(); ack_cyc.delete();
      keep_a = 1'b1; keep_b = 1'b1;
      a_write = 1'b0; a_addr = 20'h00111; b_addr = 20'h00222; mdata = 8'h77;
      a_req = 1'b1; b_req = 1'b1;
      for (int k = 0; k < 40 && order.size() < 4; k++) begin
         mdata = 8'(k * 13 + 5);
         tick();
      end
      a_req = 1'b0; b_req = 1'b0; keep_a = 1'b0; keep_b = 1'b0;
      check("rr_ack_count", 32'(order.size()), 32'd4);
      if (order.size() == 4) begin
         for (int i = 0; i < 4; i++) check("rr_order", 32'(order[i]), 32'(i % 2));
         for (int i = 1; i < 4; i++) check("rr_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd5);
      end
      ticks(6);

      // Reset in the second access cycle of an A write, B pending.
      a_write = 1'b1; a_addr = 20'h0ABCD; a_wdata = 8'h11; a_req = 1'b1;
      tick();
      b_write = 1'b0; b_addr = 20'h00042; b_req = 1'b1;
      tick();
      check("rst_pre_mwrite", 32'(bus.o_m_write), 32'd1);
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      check("rst_async_mwrite", 32'(bus.o_m_write), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("rst_b_ack_first_edge", 32'(bus.o_b_ack), 32'd1);
      check("rst_no_a_ack",         32'(bus.o_a_ack), 32'd0);
      ticks(6);

      // Random traffic with occasional asynchronous resets.
      for (int c = 0; c < 400; c++) begin
         if (!a_req && $urandom_range(0, 3) == 0) begin
            a_req = 1'b1; a_write = 1'($urandom_range(0, 1));
            a_addr = 20'($urandom); a_wdata = 8'($urandom);
         end
         if (!b_req && $urandom_range(0, 3) == 0) begin
            b_req = 1'b1; b_write = 1'($urandom_range(0, 1));
            b_addr = 20'($urandom); b_wdata = 8'($urandom);
         end
         keep_a = ($urandom_range(0, 3) == 0);
         keep_b = ($urandom_range(0, 3) == 0);
         mdata  = 8'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            #1 rst_n = 1'b0;
            model_reset();
            #1 check_all();
            tick();
            rst_n = 1'b1;
         end
         tick();
      end
      a_req = 1'b0; b_req = 1'b0; keep_a = 1'b0; keep_b = 1'b0;
      ticks(6);

      // ACCESS_CYCLES=2 instance: write then read of 0x00010, back to back.
      a2_write = 1'b1; a2_addr = 20'h00010; a2_wdata = 8'h5A; mdata2 = 8'h5A; a2_req = 1'b1;
      wr_cnt = 0; rv_cyc = -100; rv_dat = '0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus2.o_a_ack) begin
            ack2.push_back(k);
            if (ack2.size() == 1) a2_write = 1'b0; else a2_req = 1'b0;
         end
         if (bus2.o_m_write) begin
            wr_cnt++;
            check("ac2_m_addr", 32'(bus2.o_m_addr), 32'h10);
            check("ac2_m_data", 32'(bus2.o_m_data), 32'h5A);
         end
         if (bus2.o_a_rvalid) begin rv_cyc = k; rv_dat = bus2.o_a_rdata; end
      end
      a2n = ack2.size();
      k0  = (a2n == 2) ? ack2[1] : -1000;
      check("ac2_ack_count",   32'(a2n), 32'd2);
      check("ac2_write_cycles", 32'(wr_cnt), 32'd2);
      check("ac2_ack_spacing", 32'((a2n == 2) ? ack2[1] - ack2[0] : -1), 32'd4);
      // rvalid lands in the recover cycle, i.e. the third cycle counting the ack cycle.
      check("ac2_rvalid_delay", 32'(rv_cyc - k0), 32'd2);
      check("ac2_rdata",        32'(rv_dat), 32'h5A);
      check("ac2_b_rdata_idle", 32'(bus2.o_b_rdata), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
